// File: rtl/sync_ram_pkg.sv
// Shared types, constants and helpers for the parametrised synchronous RAM.
// The parity helper is only used when SYNC_RAM_PARITY_EN is defined.
package sync_ram_pkg;

    // Clear-engine states: CLEAR zeroes the array, IDLE serves user traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

    // Collision behaviour selectors for RW_MODE.
    localparam int RW_READ_FIRST  = 0;
    localparam int RW_WRITE_FIRST = 1;

    // Widest data word the parity helper covers; callers zero-extend into it.
    localparam int PARITY_MAX_W = 256;

    // Even parity: returns 1 when the word has an odd number of ones, so that
    // the word plus this bit always carries an even count. Zero-extension
    // leaves the result unchanged, which lets one function serve any DW.
    function automatic logic parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage : sync_ram_pkg

// File: rtl/sync_ram_clear_fsm.sv
// Clear engine for param_sync_ram. After reset, or on a clear request while
// idle, it sweeps every address from 0 to DEPTH-1, one write per cycle, and
// holds busy high for exactly DEPTH cycles.
module sync_ram_clear_fsm
    import sync_ram_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    ram_state_t    state;
    logic [AW-1:0] cnt;

    // The counter doubles as the clear write address.
    assign clr_addr = cnt;

    // State, counter and registered busy/write-enable; reset restarts the sweep at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy   <= 1'b1;
            clr_we <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        // Last address is written on this edge; user traffic resumes next cycle.
                        state  <= IDLE;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        clr_we <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        clr_we <= 1'b1;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    clr_we <= 1'b1;
                end
            endcase
        end
    end

endmodule : sync_ram_clear_fsm

// File: rtl/param_sync_ram.sv
// Parametrised single-port synchronous RAM with registered read, valid strobe,
// selectable read/write collision order and a hardware clear engine.
// Optional feature macro: SYNC_RAM_PARITY_EN adds a stored even-parity bit per
// word and a parity_err output that accompanies dout_valid.
// DW must not exceed sync_ram_pkg::PARITY_MAX_W when parity is enabled.
module param_sync_ram
    import sync_ram_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEPTH   = 64,
    parameter int AW      = $clog2(DEPTH),
    parameter int RW_MODE = RW_READ_FIRST
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_req,
    input  logic          ren,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy
`ifdef SYNC_RAM_PARITY_EN
    ,
    output logic          parity_err
`endif
);

`ifdef SYNC_RAM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    // Build the stored word for a data value (parity bit on top when enabled).
    function automatic logic [MW-1:0] make_word(input logic [DW-1:0] data);
`ifdef SYNC_RAM_PARITY_EN
        return {parity(PARITY_MAX_W'(data)), data};
`else
        return data;
`endif
    endfunction

    logic [MW-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic          user_ok;
    logic          user_wr;
    logic          user_rd;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word_p0;

    sync_ram_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // User traffic is dropped while clearing and in the cycle a clear is requested.
    assign user_ok = !busy && !clear_req;
    assign user_wr = user_ok && wen;
    assign user_rd = user_ok && ren;

    // Write port mux: the clear engine owns the array while it runs.
    always_comb begin
        wr_en   = user_wr;
        wr_addr = addr;
        wr_word = make_word(din);
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_word = '0;
        end
    end

    // Read word selection: write-first collisions forward the incoming data.
    always_comb begin
        rd_word_p0 = mem[addr];
        if (RW_MODE == RW_WRITE_FIRST && user_wr) begin
            rd_word_p0 = make_word(din);
        end
    end

    // Storage array; contents are data only and carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // ---- stage p0 -> p1: registered read data and its valid strobe ----
    // Read output registers; dout holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= user_rd;
            if (user_rd) begin
                dout <= rd_word_p0[DW-1:0];
            end
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    // Parity check of the word being read: recomputed parity XOR stored bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= user_rd &&
                          (parity(PARITY_MAX_W'(rd_word_p0[DW-1:0])) ^ rd_word_p0[DW]);
        end
    end
`endif

endmodule : param_sync_ram
